// File: rtl/motor_pwm_drive_pkg.sv
// Shared definitions for the rear-motor PWM drive.
// Motor speed codes must stay identical to the tracking/u-turn controller's
// encoding, because that block produces the registered code this drive consumes.
package motor_pwm_drive_pkg;

    localparam logic [1:0] MOTOR_STOP   = 2'b00;
    localparam logic [1:0] MOTOR_FOR    = 2'b01;
    localparam logic [1:0] MOTOR_BACK   = 2'b10;
    localparam logic [1:0] FAST_FORWARD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FWD  = 2'b01,
        ST_BACK = 2'b10,
        ST_DEAD = 2'b11
    } state_t;

    // Both forward codes (normal and fast) drive the bridge the same way round.
    function automatic logic is_forward(input logic [1:0] code);
        return (code == MOTOR_FOR) || (code == FAST_FORWARD);
    endfunction

endpackage

// File: rtl/motor_pwm_drive_pwm_counter.sv
// Free-running PWM period counter with duty compare.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-low reset
//   duty     - clk cycles high per period
//   pwm      - combinational compare result (count < duty)
//   boundary - high in the last cycle of each period (count == PWM_PERIOD-1)
module motor_pwm_drive_pwm_counter #(
    parameter int PWM_PERIOD = 1000,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm,
    output logic             boundary
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [CNT_W-1:0] cnt_r;

    assign boundary = (cnt_r == CNT_LAST);
    assign pwm      = (cnt_r < duty);

    // Period counter: 0 .. PWM_PERIOD-1, then wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= CNT_ZERO;
        end else if (boundary) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/motor_pwm_drive.sv
// Rear-motor H-bridge PWM drive with soft acceleration and reversal dead time.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-low reset
//   motor    - registered speed code (00 stop, 01 fwd, 10 back, 11 fast fwd)
//   in1      - H-bridge forward input (registered PWM)
//   in2      - H-bridge backward input (registered PWM)
//   duty     - currently applied duty in clk cycles per period
//   at_speed - duty has reached a nonzero target while driving
module motor_pwm_drive
    import motor_pwm_drive_pkg::*;
#(
    parameter int PWM_PERIOD = 1000,
    parameter int CNT_W      = 10,
    parameter int DUTY_FOR   = 600,
    parameter int DUTY_FAST  = 900,
    parameter int DUTY_BACK  = 600,
    parameter int RAMP_STEP  = 20,
    parameter int DEAD_TIME  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       motor,
    output logic             in1,
    output logic             in2,
    output logic [CNT_W-1:0] duty,
    output logic             at_speed
);

    localparam int DEAD_W = $clog2(DEAD_TIME + 1);

    localparam logic [CNT_W-1:0]  DUTY_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  DUTY_STEP  = CNT_W'(RAMP_STEP);
    localparam logic [CNT_W-1:0]  TGT_FOR    = CNT_W'(DUTY_FOR);
    localparam logic [CNT_W-1:0]  TGT_FAST   = CNT_W'(DUTY_FAST);
    localparam logic [CNT_W-1:0]  TGT_BACK   = CNT_W'(DUTY_BACK);
    localparam logic [DEAD_W-1:0] DEAD_ZERO  = {DEAD_W{1'b0}};
    localparam logic [DEAD_W-1:0] DEAD_ONE   = DEAD_W'(1'b1);
    localparam logic [DEAD_W-1:0] DEAD_LAST  = DEAD_W'(DEAD_TIME);

    state_t            state_r, state_nxt;
    logic [CNT_W-1:0]  duty_r, duty_nxt;
    logic [DEAD_W-1:0] dead_r, dead_nxt;
    logic [CNT_W-1:0]  target_s;
    logic              pwm_s, boundary_s;
    logic              in1_r, in2_r, at_speed_r;
    logic              in1_nxt, in2_nxt, at_speed_nxt;

    // Speeding up is stepped and saturates at the target; slowing down is
    // applied at once so the motor never keeps more torque than commanded.
    function automatic logic [CNT_W-1:0] ramp(input logic [CNT_W-1:0] cur,
                                              input logic [CNT_W-1:0] tgt);
        logic [CNT_W-1:0] res;
        if (cur >= tgt) begin
            res = tgt;
        end else if ((tgt - cur) > DUTY_STEP) begin
            res = cur + DUTY_STEP;
        end else begin
            res = tgt;
        end
        return res;
    endfunction

    motor_pwm_drive_pwm_counter #(
        .PWM_PERIOD (PWM_PERIOD),
        .CNT_W      (CNT_W)
    ) u_pwm_counter (
        .clk      (clk),
        .rst      (rst),
        .duty     (duty_r),
        .pwm      (pwm_s),
        .boundary (boundary_s)
    );

    // Target duty decoded from the speed code.
    always_comb begin
        target_s = DUTY_ZERO;
        case (motor)
            MOTOR_FOR:    target_s = TGT_FOR;
            FAST_FORWARD: target_s = TGT_FAST;
            MOTOR_BACK:   target_s = TGT_BACK;
            default:      target_s = DUTY_ZERO;
        endcase
    end

    // State, duty and dead-time counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            duty_r  <= DUTY_ZERO;
            dead_r  <= DEAD_ZERO;
        end else begin
            state_r <= state_nxt;
            duty_r  <= duty_nxt;
            dead_r  <= dead_nxt;
        end
    end

    // Next-state, duty and dead-time logic.
    always_comb begin
        state_nxt = state_r;
        duty_nxt  = duty_r;
        dead_nxt  = dead_r;
        case (state_r)
            ST_IDLE: begin
                duty_nxt = DUTY_ZERO;
                dead_nxt = DEAD_ZERO;
                if (is_forward(motor)) begin
                    state_nxt = ST_FWD;
                end else if (motor == MOTOR_BACK) begin
                    state_nxt = ST_BACK;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FWD: begin
                if (motor == MOTOR_STOP) begin
                    state_nxt = ST_IDLE;
                    duty_nxt  = DUTY_ZERO;
                end else if (motor == MOTOR_BACK) begin
                    state_nxt = ST_DEAD;
                    duty_nxt  = DUTY_ZERO;
                    dead_nxt  = DEAD_ZERO;
                end else if (boundary_s) begin
                    duty_nxt = ramp(duty_r, target_s);
                end else begin
                    duty_nxt = duty_r;
                end
            end
            ST_BACK: begin
                if (motor == MOTOR_STOP) begin
                    state_nxt = ST_IDLE;
                    duty_nxt  = DUTY_ZERO;
                end else if (is_forward(motor)) begin
                    state_nxt = ST_DEAD;
                    duty_nxt  = DUTY_ZERO;
                    dead_nxt  = DEAD_ZERO;
                end else if (boundary_s) begin
                    duty_nxt = ramp(duty_r, target_s);
                end else begin
                    duty_nxt = duty_r;
                end
            end
            ST_DEAD: begin
                // The full dead time is served even if the command swings back
                // to the original direction; only a stop cuts it short.
                duty_nxt = DUTY_ZERO;
                if (motor == MOTOR_STOP) begin
                    state_nxt = ST_IDLE;
                end else if (boundary_s) begin
                    dead_nxt = dead_r + DEAD_ONE;
                    if ((dead_r + DEAD_ONE) == DEAD_LAST) begin
                        state_nxt = is_forward(motor) ? ST_FWD : ST_BACK;
                    end else begin
                        state_nxt = ST_DEAD;
                    end
                end else begin
                    state_nxt = ST_DEAD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                duty_nxt  = DUTY_ZERO;
                dead_nxt  = DEAD_ZERO;
            end
        endcase
    end

    // Output decode: gating on the next state makes stop/reversal drop the
    // bridge inputs on the very edge that sees the new command.
    always_comb begin
        in1_nxt = 1'b0;
        in2_nxt = 1'b0;
        case (state_nxt)
            ST_FWD:  in1_nxt = pwm_s;
            ST_BACK: in2_nxt = pwm_s;
            default: begin
                in1_nxt = 1'b0;
                in2_nxt = 1'b0;
            end
        endcase
        at_speed_nxt = ((state_nxt == ST_FWD) || (state_nxt == ST_BACK)) &&
                       (target_s != DUTY_ZERO) && (duty_nxt == target_s);
    end

    // Registered bridge and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in1_r      <= 1'b0;
            in2_r      <= 1'b0;
            at_speed_r <= 1'b0;
        end else begin
            in1_r      <= in1_nxt;
            in2_r      <= in2_nxt;
            at_speed_r <= at_speed_nxt;
        end
    end

    assign in1      = in1_r;
    assign in2      = in2_r;
    assign duty     = duty_r;
    assign at_speed = at_speed_r;

endmodule

// File: tb/tb_motor_pwm_drive.sv
`timescale 1ns/1ps
module tb_motor_pwm_drive;

    localparam int PWM_PERIOD = 10;
    localparam int CNT_W      = 4;
    localparam int DUTY_FOR   = 6;
    localparam int DUTY_FAST  = 9;
    localparam int DUTY_BACK  = 6;
    localparam int RAMP_STEP  = 2;
    localparam int DEAD_TIME  = 2;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic [1:0]       motor = 2'b00;
    logic             in1, in2, at_speed;
    logic [CNT_W-1:0] duty;

    int checks = 0;
    int errors = 0;
    int ph     = 0;      // bench's own model of the free-running PWM counter
    bit bnd    = 1'b0;   // last edge was a period boundary

    typedef struct {
        int duty;   // duty expected right after the boundary
        int n1;     // in1 high cycles over the period ending at that boundary
        int n2;     // in2 high cycles over the same period
        int spd;    // at_speed expected right after the boundary
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    motor_pwm_drive #(
        .PWM_PERIOD (PWM_PERIOD),
        .CNT_W      (CNT_W),
        .DUTY_FOR   (DUTY_FOR),
        .DUTY_FAST  (DUTY_FAST),
        .DUTY_BACK  (DUTY_BACK),
        .RAMP_STEP  (RAMP_STEP),
        .DEAD_TIME  (DEAD_TIME)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .motor    (motor),
        .in1      (in1),
        .in2      (in2),
        .duty     (duty),
        .at_speed (at_speed)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: advance the counter model on the rising edge, return at the falling edge.
    task automatic step();
        @(posedge clk);
        bnd = (ph == PWM_PERIOD - 1);
        ph  = bnd ? 0 : ph + 1;
        @(negedge clk);
    endtask

    task automatic expect_period(input int d, input int n1, input int n2, input int spd);
        exp_t e;
        e.duty = d;
        e.n1   = n1;
        e.n2   = n2;
        e.spd  = spd;
        sb.push_back(e);
    endtask

    // Run up to and including the next boundary edge, counting bridge pulses,
    // then compare against the oldest scoreboard entry.
    task automatic period_check(input string tag);
        int   n1   = 0;
        int   n2   = 0;
        int   both = 0;
        exp_t e;
        bnd = 1'b0;
        for (int i = 0; i < PWM_PERIOD + 2 && !bnd; i++) begin
            step();
            if (in1 === 1'b1) n1++;
            if (in2 === 1'b1) n2++;
            if ((in1 === 1'b1) && (in2 === 1'b1)) both++;
        end
        check($sformatf("%s_boundary", tag), 32'(bnd), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s_duty", tag), 32'(duty), 32'(e.duty));
            check($sformatf("%s_in1_pulses", tag), 32'(n1), 32'(e.n1));
            check($sformatf("%s_in2_pulses", tag), 32'(n2), 32'(e.n2));
            check($sformatf("%s_at_speed", tag), 32'(at_speed), 32'(e.spd));
            check($sformatf("%s_overlap", tag), 32'(both), 32'd0);
        end
    endtask

    initial begin
        // Reset held with a forward command: everything stays at zero.
        rst   = 1'b0;
        motor = 2'b01;
        repeat (3) @(negedge clk);
        check("rst_in1", 32'(in1), 32'd0);
        check("rst_in2", 32'(in2), 32'd0);
        check("rst_duty", 32'(duty), 32'd0);
        check("rst_at_speed", 32'(at_speed), 32'd0);

        // Release with stop: outputs remain quiet.
        motor = 2'b00;
        rst   = 1'b1;
        ph    = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            check("idle_quiet", {28'd0, in1, in2, at_speed, 1'b0} | 32'(duty), 32'd0);
        end

        // Forward ramp from IDLE: 2, 4, 6.
        motor = 2'b01;
        expect_period(2, 0, 0, 0);
        expect_period(4, 2, 0, 0);
        expect_period(6, 4, 0, 1);
        repeat (3) period_check("fwd_ramp");

        // Retarget to fast forward, then back down with no ramp.
        motor = 2'b11;
        expect_period(8, 6, 0, 0);
        expect_period(9, 8, 0, 1);
        repeat (2) period_check("fast_ramp");
        motor = 2'b01;
        expect_period(6, 9, 0, 1);
        period_check("fast_to_fwd");
        expect_period(6, 6, 0, 1);
        period_check("fwd_steady");

        // Reversal mid-period: immediate coast, dead time, then backward ramp.
        repeat (3) step();
        motor = 2'b10;
        step();
        check("rev_in1", 32'(in1), 32'd0);
        check("rev_in2", 32'(in2), 32'd0);
        check("rev_duty", 32'(duty), 32'd0);
        check("rev_at_speed", 32'(at_speed), 32'd0);
        expect_period(0, 0, 0, 0);
        period_check("dead_partial");
        expect_period(0, 0, 0, 0);
        period_check("dead_full");
        expect_period(2, 0, 0, 0);
        expect_period(4, 0, 2, 0);
        expect_period(6, 0, 4, 1);
        expect_period(6, 0, 6, 1);
        repeat (4) period_check("back_ramp");

        // Stop while reversing at speed.
        motor = 2'b00;
        step();
        check("stop_back_in2", 32'(in2), 32'd0);
        check("stop_back_duty", 32'(duty), 32'd0);
        check("stop_back_at_speed", 32'(at_speed), 32'd0);
        expect_period(0, 0, 0, 0);
        period_check("stop_back_idle");

        // Forward to speed, then stop mid-period.
        motor = 2'b01;
        expect_period(2, 0, 0, 0);
        expect_period(4, 2, 0, 0);
        expect_period(6, 4, 0, 1);
        repeat (3) period_check("fwd_ramp2");
        repeat (2) step();
        check("fwd_pulse_high", 32'(in1), 32'd1);
        motor = 2'b00;
        step();
        check("stop_fwd_in1", 32'(in1), 32'd0);
        check("stop_fwd_duty", 32'(duty), 32'd0);
        check("stop_fwd_at_speed", 32'(at_speed), 32'd0);
        expect_period(0, 0, 0, 0);
        period_check("stop_fwd_idle");

        // Stop during dead time goes straight to IDLE: a following backward
        // command then ramps at the next boundary without any dead time.
        motor = 2'b01;
        repeat (2) step();
        motor = 2'b10;
        repeat (2) step();
        check("abort_dead_duty", 32'(duty), 32'd0);
        motor = 2'b00;
        step();
        check("abort_in1", 32'(in1), 32'd0);
        check("abort_in2", 32'(in2), 32'd0);
        check("abort_duty", 32'(duty), 32'd0);
        motor = 2'b10;
        expect_period(2, 0, 0, 0);
        expect_period(4, 0, 2, 0);
        repeat (2) period_check("abort_then_back");

        // Asynchronous reset between clock edges at duty 4.
        repeat (3) step();
        check("pre_reset_in2", 32'(in2), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("async_in1", 32'(in1), 32'd0);
        check("async_in2", 32'(in2), 32'd0);
        check("async_duty", 32'(duty), 32'd0);
        check("async_at_speed", 32'(at_speed), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ph  = 0;
        expect_period(2, 0, 0, 0);
        expect_period(4, 0, 2, 0);
        repeat (2) period_check("post_reset_ramp");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
